// File: rtl/phj_phase_ctrl.sv
// phj_phase_ctrl: phase sequencer for a partitioned hash join.
// Walks IDLE -> BUILD -> DRAIN_B -> PROBE -> DRAIN_P -> DONE.
// It gates host beats into the stream converter and meters probe beats
// with serial-number credits.
// Optional macro PHJ_PHASE_STATS_EN adds the probe_tuples statistics output.
module phj_phase_ctrl #(
  parameter int MAX_IN_TRANSIT = 4,
  parameter int CW             = $clog2(MAX_IN_TRANSIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_valid,
  input  logic          in_last_BUILD,
  input  logic          in_last_PROBE,
  output logic          in_ready,
  output logic [7:0]    dp_valid,
  input  logic          dp_ready,
  output logic          dp_is_probe,
  input  logic [7:0]    build_done,
  input  logic          release_next,
  input  logic          probe_done,
  output logic [2:0]    phase,
  output logic [CW-1:0] credits,
  output logic          done,
  output logic          err
`ifdef PHJ_PHASE_STATS_EN
  ,
  output logic [31:0]   probe_tuples
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUILD   = 3'd1,
    DRAIN_B = 3'd2,
    PROBE   = 3'd3,
    DRAIN_P = 3'd4,
    DONE    = 3'd5
  } phaseState_e;

  localparam logic [CW-1:0] CreditMax = CW'(MAX_IN_TRANSIT);

  phaseState_e   state_q;
  logic [CW-1:0] credits_q, credits_d;
  logic [7:0]    buildMask_q, buildMask_d;
  logic          done_q;
  logic          err_q, err_d;
  logic          gateOpen;
  logic          accept;
  logic          probeAccept;
  logic          creditOverflow;

  // Lane gate is open in BUILD, or in PROBE while a credit is free.
  // in_ready further needs the converter to be ready.
  always_comb begin
    gateOpen    = (state_q == BUILD) || ((state_q == PROBE) && (credits_q != '0));
    in_ready    = gateOpen && dp_ready;
    dp_valid    = gateOpen ? in_valid : 8'h00;
    accept      = in_ready && (in_valid != 8'h00);
    probeAccept = accept && (state_q == PROBE);
  end

  // Credit bookkeeping: a probe beat takes a credit and a retired serial
  // number returns one. When both happen in one cycle they cancel. A return
  // at full credit saturates and counts as a protocol error.
  always_comb begin
    credits_d      = credits_q;
    creditOverflow = 1'b0;
    if (probeAccept && !release_next) begin
      credits_d = credits_q - 1'b1;
    end else if (release_next && !probeAccept) begin
      if (credits_q == CreditMax) begin
        creditOverflow = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end
  end

  // Sticky build-completion mask and sticky error.
  // Each hash table may report its last_processed at any time.
  always_comb begin
    buildMask_d = buildMask_q | build_done;
    if (state_q == IDLE && start) begin
      buildMask_d = 8'h00;
    end
    err_d = err_q || creditOverflow
          || (accept && (state_q == BUILD) && in_last_PROBE)
          || (accept && (state_q == PROBE) && in_last_BUILD);
  end

  // Phase state machine with registered done pulse, credits, mask and error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      credits_q   <= CreditMax;
      buildMask_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      buildMask_q <= buildMask_d;
      err_q       <= err_d;
      done_q      <= 1'b0;
      case (state_q)
        IDLE:    if (start) state_q <= BUILD;
        BUILD:   if (accept && in_last_BUILD) state_q <= DRAIN_B;
        DRAIN_B: if (buildMask_q == 8'hFF) state_q <= PROBE;
        PROBE:   if (accept && in_last_PROBE) state_q <= DRAIN_P;
        DRAIN_P: begin
          if (probe_done && (credits_q == CreditMax)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign phase       = state_q;
  assign credits     = credits_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dp_is_probe = (state_q == PROBE);

`ifdef PHJ_PHASE_STATS_EN
  logic [3:0]  laneCount;
  logic [31:0] probeTuples_q;

  // Population count of the lanes offered in the current beat.
  always_comb begin
    laneCount = 4'd0;
    for (int i = 0; i < 8; i++) begin
      laneCount = laneCount + {3'b000, in_valid[i]};
    end
  end

  // Running count of probe tuples for this join, wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      probeTuples_q <= 32'd0;
    end else if (state_q == IDLE && start) begin
      probeTuples_q <= 32'd0;
    end else if (probeAccept) begin
      probeTuples_q <= probeTuples_q + {28'd0, laneCount};
    end
  end

  assign probe_tuples = probeTuples_q;
`endif

endmodule

// File: tb/tb_phj_phase_ctrl.sv
// tb_phj_phase_ctrl: directed, self-checking bench for phj_phase_ctrl.
module tb_phj_phase_ctrl;

  localparam int MaxInTransit = 4;
  localparam int Cw = $clog2(MaxInTransit + 1);

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    in_valid;
  logic          in_last_BUILD;
  logic          in_last_PROBE;
  logic          in_ready;
  logic [7:0]    dp_valid;
  logic          dp_ready;
  logic          dp_is_probe;
  logic [7:0]    build_done;
  logic          release_next;
  logic          probe_done;
  logic [2:0]    phase;
  logic [Cw-1:0] credits;
  logic          done;
  logic          err;
`ifdef PHJ_PHASE_STATS_EN
  logic [31:0]   probe_tuples;
`endif

  int checkCount = 0;
  int errorCount = 0;

  phj_phase_ctrl #(.MAX_IN_TRANSIT(MaxInTransit)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_valid      (in_valid),
    .in_last_BUILD (in_last_BUILD),
    .in_last_PROBE (in_last_PROBE),
    .in_ready      (in_ready),
    .dp_valid      (dp_valid),
    .dp_ready      (dp_ready),
    .dp_is_probe   (dp_is_probe),
    .build_done    (build_done),
    .release_next  (release_next),
    .probe_done    (probe_done),
    .phase         (phase),
    .credits       (credits),
    .done          (done),
    .err           (err)
`ifdef PHJ_PHASE_STATS_EN
    ,
    .probe_tuples  (probe_tuples)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one set of inputs just after a rising edge and lets them settle.
  task automatic applyStimulus(input logic [7:0] valid, input logic lastB, input logic lastP,
                               input logic [7:0] bdone, input logic rel, input logic pdone);
    in_valid      = valid;
    in_last_BUILD = lastB;
    in_last_PROBE = lastP;
    build_done    = bdone;
    release_next  = rel;
    probe_done    = pdone;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dp_ready = 1'b1;
    applyStimulus(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_credits", 32'(credits), 32'd4);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_dp_valid", 32'(dp_valid), 32'h00);

    // Begin a join and walk the build phase.
    reset = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("build_phase", 32'(phase), 32'd1);
    applyStimulus(8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("build_in_ready", 32'(in_ready), 32'd1);
    checkOutput("build_dp_valid", 32'(dp_valid), 32'h0F);
    dp_ready = 1'b0; #1;
    checkOutput("build_stall_ready", 32'(in_ready), 32'd0);
    checkOutput("build_stall_dpv", 32'(dp_valid), 32'h0F);
    tick();
    checkOutput("build_stall_phase", 32'(phase), 32'd1);
    dp_ready = 1'b1;
    tick(); tick();
    applyStimulus(8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("drainb_phase", 32'(phase), 32'd2);
    checkOutput("drainb_credits", 32'(credits), 32'd4);
    checkOutput("drainb_in_ready", 32'(in_ready), 32'd0);

    // Build mask completes over two cycles; PROBE follows one cycle later.
    applyStimulus(8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0);
    tick();
    checkOutput("mask_half_phase", 32'(phase), 32'd2);
    applyStimulus(8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0);
    tick();
    checkOutput("mask_full_phase", 32'(phase), 32'd2);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("probe_phase", 32'(phase), 32'd3);
    checkOutput("probe_flag", 32'(dp_is_probe), 32'd1);

    // Six probe beats without release: only four are accepted.
    applyStimulus(8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("probe_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("probe_credits0", 32'(credits), 32'd0);
    checkOutput("probe_stall_ready", 32'(in_ready), 32'd0);
    checkOutput("probe_stall_dpv", 32'(dp_valid), 32'h00);
    tick(); tick();
    checkOutput("probe_credits_hold", 32'(credits), 32'd0);
`ifdef PHJ_PHASE_STATS_EN
    checkOutput("probe_tuples", probe_tuples, 32'd8);
`endif

    // Return two credits, then accept and release together.
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    checkOutput("release_credits2", 32'(credits), 32'd2);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("same_cycle_credits", 32'(credits), 32'd2);
    applyStimulus(8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("drainp_phase", 32'(phase), 32'd4);
    checkOutput("drainp_credits", 32'(credits), 32'd1);

    // Drain with an early probe_done that must not complete.
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    checkOutput("drainp_credits3", 32'(credits), 32'd3);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("early_pdone_phase", 32'(phase), 32'd4);
    checkOutput("early_pdone_done", 32'(done), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("drainp_credits4", 32'(credits), 32'd4);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("done_phase", 32'(phase), 32'd5);
    checkOutput("done_pulse", 32'(done), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("after_done_phase", 32'(phase), 32'd0);
    checkOutput("after_done_pulse", 32'(done), 32'd0);
    checkOutput("clean_err", 32'(err), 32'd0);

    // Release at full credit: sticky error, credits saturate.
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("overflow_err", 32'(err), 32'd1);
    checkOutput("overflow_credits", 32'(credits), 32'd4);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("overflow_err_sticky", 32'(err), 32'd1);

    // Fresh join: wrong last flag in BUILD, then reset mid-PROBE.
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("rst2_err", 32'(err), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    applyStimulus(8'h80, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("bad_last_err", 32'(err), 32'd1);
    checkOutput("bad_last_phase", 32'(phase), 32'd1);
    applyStimulus(8'h80, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("rerun_probe_phase", 32'(phase), 32'd3);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick(); tick();
    checkOutput("pre_abort_credits", 32'(credits), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("abort_phase", 32'(phase), 32'd0);
    checkOutput("abort_credits", 32'(credits), 32'd4);
    checkOutput("abort_err", 32'(err), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/phj_phase_ctrl.md
PHJ_PHASE_CTRL -- requirements
Module: phj_phase_ctrl

Interface
REQ-001 SHALL have parameter MAX_IN_TRANSIT, default 4: number of probe beats allowed in flight (serial-number credits), range 1..255.
REQ-002 SHALL have parameter CW, default $clog2(MAX_IN_TRANSIT+1): credit counter width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a join.
REQ-006 SHALL have port in_valid  input  8  host lane-valid mask, one bit per 64-bit tuple.
REQ-007 SHALL have port in_last_BUILD  input  1  qualifies the final build beat.
REQ-008 SHALL have port in_last_PROBE  input  1  qualifies the final probe beat.
REQ-009 SHALL have port in_ready  output  1  host backpressure.
REQ-010 SHALL have port dp_valid  output  8  gated lane mask to the stream converter.
REQ-011 SHALL have port dp_ready  input  1  stream converter ready.
REQ-012 SHALL have port dp_is_probe  output  1  1 while the current phase is PROBE.
REQ-013 SHALL have port build_done  input  8  per-partition build last_processed from the 8 hash tables.
REQ-014 SHALL have port release_next  input  1  one serial number retired by command-and-control.
REQ-015 SHALL have port probe_done  input  1  global last_processed from command-and-control.
REQ-016 SHALL have ports phase (output, 3, state code), credits (output, CW, free credits), done (output, 1, completion pulse), err (output, 1, sticky protocol error).

Function
REQ-017 SHALL implement states IDLE=0, BUILD=1, DRAIN_B=2, PROBE=3, DRAIN_P=4, DONE=5, driven on phase.
REQ-018 SHALL define accept = in_ready && (in_valid != 0).
REQ-019 SHALL drive in_ready = dp_ready && (state==BUILD || (state==PROBE && credits!=0)), combinationally, zero latency.
REQ-020 SHALL drive dp_valid = in_valid when in_ready conditions except dp_ready hold, else 8'h00.
REQ-021 SHALL transition IDLE->BUILD on start; start outside IDLE is ignored.
REQ-022 SHALL transition BUILD->DRAIN_B on accept with in_last_BUILD=1.
REQ-023 SHALL OR build_done into an 8-bit sticky register (cleared on IDLE->BUILD) and move DRAIN_B->PROBE the cycle after it equals 8'hFF.
REQ-024 SHALL transition PROBE->DRAIN_P on accept with in_last_PROBE=1.
REQ-025 SHALL transition DRAIN_P->DONE when probe_done=1 and credits==MAX_IN_TRANSIT in the same cycle.
REQ-026 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-027 SHALL decrement credits on accept in PROBE, increment on release_next, and hold them when both occur in the same cycle.
REQ-028 SHALL saturate credits at MAX_IN_TRANSIT and set err on release_next while credits==MAX_IN_TRANSIT with no simultaneous decrement.
REQ-029 SHALL set err on accept with in_last_PROBE=1 in BUILD, or with in_last_BUILD=1 in PROBE; the state machine proceeds unaffected.
REQ-030 SHALL never underflow credits: accept in PROBE cannot occur at credits==0 (REQ-019).

Reset
REQ-031 SHALL on reset set state IDLE, credits=MAX_IN_TRANSIT, sticky build mask 0, err=0, done=0, stats counter 0; in_ready=0 and dp_valid=0 follow.
REQ-032 SHALL abort any phase on reset mid-operation, discarding in-flight credit state.

Configuration
REQ-033 SHALL, with PHJ_PHASE_STATS_EN defined, add output probe_tuples (32 bits): popcount of in_valid summed per accept in PROBE, cleared on IDLE->BUILD, wrapping modulo 2^32.
REQ-034 SHALL, without PHJ_PHASE_STATS_EN, omit the probe_tuples port and its logic; all other behaviour is identical.

Verification
REQ-035 SHALL cover: start, 3 build beats (last on 3rd), build_done=8'hFF -> phase 1,2,3 in order, PROBE entered one cycle after the mask completes.
REQ-036 SHALL cover: MAX_IN_TRANSIT=4, 6 probe beats with no release -> in_ready=0 after the 4th accept, credits=0, dp_valid=0.
REQ-037 SHALL cover: credits=2, accept and release_next in the same cycle -> credits stays 2.
REQ-038 SHALL cover: in DRAIN_P, probe_done=1 with credits=3 of 4 -> no DONE; release_next then probe_done -> done high exactly 1 cycle, phase returns to 0.
REQ-039 SHALL cover: release_next at credits=4 of 4 -> err=1 sticky, credits stays 4.
REQ-040 SHALL cover: reset asserted in PROBE with credits=1 -> next cycle phase=0, credits=4, err=0, in_ready=0.
